// File: rtl/fmul_result_packer_if.sv
// Handshake and data bundle between the FP multiplier, the result packer and the consumer.
interface fmul_result_packer_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [23:0] in_frac;
  logic        in_error;
  logic        in_overflow;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        out_nan;
  logic        out_inf;
  logic        out_zero;

  modport master (
    output in_valid, in_sign, in_exp, in_frac, in_error, in_overflow, out_ready,
    input  in_ready, out_valid, out_word, out_nan, out_inf, out_zero
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_frac, in_error, in_overflow, out_ready,
    output in_ready, out_valid, out_word, out_nan, out_inf, out_zero
  );
endinterface

// File: rtl/fmul_result_packer.sv
// Packs unpacked multiplier results into IEEE-754 single words, buffers them in a
// 2-entry valid/ready FIFO and keeps sticky exception flags plus saturating counters.
module fmul_result_packer #(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fmul_result_packer_if.slave  bus,
  input  logic                 clr_flags,
  output logic                 flag_invalid,
  output logic                 flag_overflow,
  output logic [CNT_W-1:0]     nan_count,
  output logic [CNT_W-1:0]     ovf_count
);

  // Entry layout: {nan, inf, zero, word[31:0]}
  typedef logic [34:0] entry_t;

  entry_t           entry_q [2];
  logic [1:0]       count_q, count_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             inv_q, inv_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] nan_cnt_q, nan_cnt_d;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic             push, pop;
  entry_t           packed_d;
  entry_t           head;
  logic             frac_hidden_unused;

  // The hidden bit is implied by the exponent and never stored.
  assign frac_hidden_unused = bus.in_frac[23];

  function automatic entry_t pack_result(input logic s, input logic [7:0] e,
                                         input logic [22:0] f, input logic err,
                                         input logic ovf);
    entry_t r;
    if (err)                      r = {3'b100, 32'h7FC0_0000};
    else if (ovf || e == 8'hFF)   r = {3'b010, s, 8'hFF, 23'd0};
    else if (e == 8'h00)          r = {3'b001, s, 31'd0};
    else                          r = {3'b000, s, e, f};
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign bus.in_ready  = (count_q != 2'd2);
  assign bus.out_valid = (count_q != 2'd0);
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;
  assign packed_d      = pack_result(bus.in_sign, bus.in_exp, bus.in_frac[22:0],
                                     bus.in_error, bus.in_overflow);

  assign head          = entry_q[rd_ptr_q];
  assign bus.out_word  = head[31:0];
  assign bus.out_zero  = head[32];
  assign bus.out_inf   = head[33];
  assign bus.out_nan   = head[34];

  assign flag_invalid  = inv_q;
  assign flag_overflow = ovf_q;
  assign nan_count     = nan_cnt_q;
  assign ovf_count     = ovf_cnt_q;

  // Next-state for FIFO occupancy/pointers and the exception status; set beats clear.
  always_comb begin
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    inv_d     = clr_flags ? 1'b0 : inv_q;
    ovf_d     = clr_flags ? 1'b0 : ovf_q;
    nan_cnt_d = clr_flags ? '0 : nan_cnt_q;
    ovf_cnt_d = clr_flags ? '0 : ovf_cnt_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (push && bus.in_error) begin
      inv_d     = 1'b1;
      nan_cnt_d = sat_inc(nan_cnt_d);
    end else if (push && bus.in_overflow) begin
      ovf_d     = 1'b1;
      ovf_cnt_d = sat_inc(ovf_cnt_d);
    end
  end

  // State registers; storage is written only on push, before which the word is already packed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      inv_q      <= 1'b0;
      ovf_q      <= 1'b0;
      nan_cnt_q  <= '0;
      ovf_cnt_q  <= '0;
      entry_q[0] <= '0;
      entry_q[1] <= '0;
    end else begin
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      inv_q     <= inv_d;
      ovf_q     <= ovf_d;
      nan_cnt_q <= nan_cnt_d;
      ovf_cnt_q <= ovf_cnt_d;
      if (push) entry_q[wr_ptr_q] <= packed_d;
    end
  end

endmodule

// File: tb/tb_fmul_result_packer.sv
// Randomised and directed bench for fmul_result_packer with a queue-based reference model.
module tb_fmul_result_packer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr_flags = 1'b0;
  logic       flag_invalid, flag_overflow;
  logic [7:0] nan_count, ovf_count;

  fmul_result_packer_if bus ();

  fmul_result_packer #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .clr_flags(clr_flags),
    .flag_invalid(flag_invalid), .flag_overflow(flag_overflow),
    .nan_count(nan_count), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: queue of {nan,inf,zero,word}, flags and counters as plain ints.
  logic [34:0] mq[$];
  bit          m_inv = 0, m_ovf = 0;
  int          m_nc = 0, m_oc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [34:0] model_pack(input logic s, input logic [7:0] e,
                                             input logic [23:0] f, input logic err,
                                             input logic ovf);
    logic [31:0] w;
    logic [2:0]  c;
    if (err) begin
      w = 32'h7FC00000; c = 3'b100;
    end else if (ovf || e == 8'd255) begin
      w = s ? 32'hFF800000 : 32'h7F800000; c = 3'b010;
    end else if (e == 8'd0) begin
      w = s ? 32'h80000000 : 32'h0; c = 3'b001;
    end else begin
      w = (32'(s) << 31) | (32'(e) << 23) | (32'(f) & 32'h007FFFFF); c = 3'b000;
    end
    return {c, w};
  endfunction

  // Advance one clock; the model consumes the inputs seen at the rising edge.
  task automatic step();
    bit push, pop;
    @(posedge clk);
    push = bus.in_valid && (mq.size() < 2);
    pop  = (mq.size() > 0) && bus.out_ready;
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(model_pack(bus.in_sign, bus.in_exp, bus.in_frac,
                                      bus.in_error, bus.in_overflow));
    if (clr_flags) begin m_inv = 0; m_ovf = 0; m_nc = 0; m_oc = 0; end
    if (push && bus.in_error) begin
      m_inv = 1; m_nc = (m_nc >= 255) ? 255 : m_nc + 1;
    end else if (push && bus.in_overflow) begin
      m_ovf = 1; m_oc = (m_oc >= 255) ? 255 : m_oc + 1;
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [7:0] e,
                       input logic [23:0] f, input logic err, input logic ovf);
    bus.in_valid = v; bus.in_sign = s; bus.in_exp = e; bus.in_frac = f;
    bus.in_error = err; bus.in_overflow = ovf;
  endtask

  function automatic logic [31:0] normal_word(input logic s, input logic [7:0] e,
                                              input logic [23:0] f);
    return {s, e, f[22:0]};
  endfunction

  // Compare process: every falling edge outside reset the DUT must match the model.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
      check("in_ready",  32'(bus.in_ready),  32'(mq.size() != 2));
      if (mq.size() != 0) begin
        check("out_word", bus.out_word, mq[0][31:0]);
        check("out_class", {29'd0, bus.out_nan, bus.out_inf, bus.out_zero}, 32'(mq[0][34:32]));
      end
      check("flag_invalid",  32'(flag_invalid),  32'(m_inv));
      check("flag_overflow", 32'(flag_overflow), 32'(m_ovf));
      check("nan_count", 32'(nan_count), 32'(m_nc));
      check("ovf_count", 32'(ovf_count), 32'(m_oc));
    end
  end

  initial begin
    logic [31:0] wa, wb, wc, w;
    logic [7:0]  e;
    logic [23:0] f;
    int          oc_before;
    drive(0, 0, 0, 0, 0, 0);
    bus.out_ready = 1'b0;
    #2;
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_in_ready",  32'(bus.in_ready),  32'd1);
    check("reset_out_word",  bus.out_word, 32'd0);
    check("reset_class", {29'd0, bus.out_nan, bus.out_inf, bus.out_zero}, 32'd0);
    check("reset_counts", {nan_count, ovf_count, 14'd0, flag_invalid, flag_overflow}, 32'd0);
    #10 rst_n = 1'b1;

    // Normal value 3.0
    bus.out_ready = 1'b1;
    drive(1, 0, 8'h80, 24'hC00000, 0, 0);
    step();
    check("lit_normal_word", bus.out_word, 32'h40400000);
    check("lit_normal_ready", 32'(bus.in_ready), 32'd1);
    // Invalid -> quiet NaN
    drive(1, 1, 8'h12, 24'h123456, 1, 0);
    step();
    check("lit_nan_word", bus.out_word, 32'h7FC00000);
    check("lit_nan_flags", {29'd0, bus.out_nan, flag_invalid, nan_count == 8'd1}, 32'd7);
    // Overflow -> -inf
    drive(1, 1, 8'h40, 24'h800001, 0, 1);
    step();
    check("lit_inf_word", bus.out_word, 32'hFF800000);
    check("lit_inf_flags", {30'd0, bus.out_inf, ovf_count == 8'd1}, 32'd3);
    // Zero exponent -> -0
    drive(1, 1, 8'h00, 24'hABCDEF, 0, 0);
    step();
    check("lit_zero_word", bus.out_word, 32'h80000000);
    check("lit_zero_class", 32'(bus.out_zero), 32'd1);
    drive(0, 0, 0, 0, 0, 0);
    step();
    step();

    // Backpressure: A, B fill the FIFO, C is held
    bus.out_ready = 1'b0;
    wa = normal_word(0, 8'h81, 24'h812345); wb = normal_word(1, 8'h7E, 24'hF00001);
    wc = normal_word(0, 8'h90, 24'h80000F);
    drive(1, 0, 8'h81, 24'h812345, 0, 0); step();
    drive(1, 1, 8'h7E, 24'hF00001, 0, 0); step();
    check("bp_full_ready", 32'(bus.in_ready), 32'd0);
    drive(1, 0, 8'h90, 24'h80000F, 0, 0); step(); step();
    check("bp_hold_head", bus.out_word, wa);
    bus.out_ready = 1'b1;
    step();
    check("bp_second", bus.out_word, wb);
    check("bp_no_accept_when_full", 32'(mq.size()), 32'd1);
    step();
    check("bp_third", bus.out_word, wc);
    drive(0, 0, 0, 0, 0, 0);
    step();
    check("bp_drained", 32'(bus.out_valid), 32'd0);

    // Push and pop together at count 1
    drive(1, 0, 8'h3F, 24'h800000, 0, 0); step();
    for (int i = 0; i < 10; i++) begin
      e = 8'($urandom_range(1, 254)); f = 24'($urandom);
      w = normal_word(f[5], e, f);
      drive(1, f[5], e, f, 0, 0);
      step();
      check("stream_word", bus.out_word, w);
      check("stream_count1", {30'd0, bus.out_valid, bus.in_ready}, 32'd3);
    end
    drive(0, 0, 0, 0, 0, 0); step(); step();

    // Counter saturation, overflow ignored when error is set
    oc_before = m_oc;
    for (int i = 0; i < 300; i++) begin
      drive(1, 1'($urandom), 8'($urandom), 24'($urandom), 1, 1'($urandom));
      step();
    end
    check("lit_nan_sat", 32'(nan_count), 32'd255);
    check("ovf_unchanged", 32'(ovf_count), 32'(oc_before));
    clr_flags = 1'b1;
    drive(1, 0, 8'h01, 24'h0, 1, 0);
    step();
    clr_flags = 1'b0;
    check("lit_clr_set_wins", {23'd0, nan_count, flag_invalid}, {23'd0, 8'd1, 1'b1});
    check("lit_clr_ovf", {23'd0, ovf_count, flag_overflow}, 32'd0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 3))
        0: e = 8'h00;
        1: e = 8'hFF;
        default: e = 8'($urandom_range(1, 254));
      endcase
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), e, 24'($urandom),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0));
      bus.out_ready = 1'($urandom_range(0, 2) != 0);
      clr_flags = 1'($urandom_range(0, 31) == 0);
      step();
    end
    clr_flags = 1'b0;

    // Reset with two buffered entries and flags set
    bus.out_ready = 1'b0;
    drive(1, 0, 0, 0, 1, 0); step(); step();
    drive(1, 0, 8'h55, 24'h0, 0, 1); step();
    drive(0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_word", bus.out_word, 32'd0);
    check("rst_status", {nan_count, ovf_count, 14'd0, flag_invalid, flag_overflow}, 32'd0);
    mq.delete(); m_inv = 0; m_ovf = 0; m_nc = 0; m_oc = 0;
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    drive(1, 0, 8'h81, 24'hA00000, 0, 0);
    step();
    check("post_rst_word", bus.out_word, 32'h40A00000);
    check("post_rst_valid", 32'(bus.out_valid), 32'd1);
    drive(0, 0, 0, 0, 0, 0);
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fmul_result_packer.md
# fmul_result_packer

Two-entry elastic output stage that sits directly downstream of the floating-point multiplier. Each cycle it can accept the multiplier's unpacked result (sign, 8-bit exponent, 24-bit fraction with explicit hidden bit, error and overflow flags). It packs the result into an IEEE-754 single-precision word, classifies it, and holds it in a valid/ready FIFO until the consumer takes it. It also keeps sticky exception flags and saturating exception counters for software status reads.

## Interface
- CNT_W, 8, width of each saturating exception counter
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  multiplier result present
- in_ready  out  1  stage can accept; equals (count != 2)
- in_sign  in  1  result sign
- in_exp  in  8  biased exponent
- in_frac  in  24  fraction; bit 23 is the hidden bit, not packed
- in_error  in  1  invalid operation (inf × 0)
- in_overflow  in  1  exponent overflow
- out_valid  out  1  head entry valid; equals (count != 0)
- out_ready  in  1  consumer takes head entry
- out_word  out  32  packed IEEE-754 word of head entry
- out_nan, out_inf, out_zero  out  1 each  classification of head entry
- clr_flags  in  1  synchronous clear of flags and counters
- flag_invalid  out  1  sticky: some accepted result had in_error
- flag_overflow  out  1  sticky: some accepted result had in_overflow
- nan_count  out  CNT_W  accepted in_error results, saturating
- ovf_count  out  CNT_W  accepted in_overflow results, saturating

## Operation
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- Packing is done before storage. Entries hold word[31:0] plus 3 class bits. Priority, highest first:
  - in_error: word = 32'h7FC0_0000 (canonical quiet NaN, sign forced 0); nan = 1.
  - in_overflow: word = {in_sign, 8'hFF, 23'd0}; inf = 1.
  - in_exp == 8'hFF: word = {in_sign, 8'hFF, 23'd0}; inf = 1. The fraction is ignored.
  - in_exp == 0: word = {in_sign, 31'd0}; zero = 1. Signed zero is preserved.
  - Otherwise: word = {in_sign, in_exp, in_frac[22:0]}; all class bits 0.
- Storage is a 2-entry circular FIFO.
  - 1-bit write pointer wr_ptr, 1-bit read pointer rd_ptr, 2-bit count.
  - Pointers wrap 1 → 0.
  - Outputs are driven from entry[rd_ptr].
- Count update:
  - Push only: count + 1.
  - Pop only: count − 1.
  - Push and pop together: count unchanged. This is legal only when count == 1, since in_ready = 0 at count == 2.
- Full (count == 2): in_ready = 0. A simultaneous pop does not re-enable acceptance in the same cycle; there is no combinational ready path from out_ready to in_ready.
- Empty (count == 0): out_valid = 0. out_word and the class outputs show stale entry contents and are don't-care. There is no bypass: input never reaches the output combinationally.
- Status flags and counters:
  - They update on push, not on pop.
  - flag_invalid and flag_overflow are set by a push whose in_error / in_overflow is 1.
  - Counters increment by 1 per such push and saturate at 2^CNT_W − 1.
  - in_overflow is counted only when in_error = 0, matching packing priority.
- clr_flags:
  - Clears both flags and both counters.
  - If a qualifying push occurs in the same cycle, the set wins: the flag = 1 and the counter = 1.
  - clr_flags does not affect the FIFO.

## Timing
- Latency: push at rising edge N → out_valid = 1 and out_word valid from edge N onward (visible in the cycle after N). Minimum latency is 1 cycle.
- Throughput: 1 result per cycle when out_ready is held high. With out_ready low, 2 results are absorbed, then in_ready drops.
- in_valid may be held while in_ready = 0. Input data is sampled only on push.
- The consumer holds out_ready as it wishes. The head entry is stable until popped.
- Reset values, asserted immediately on rst_n falling and held while low:
  - count, wr_ptr, rd_ptr = 0
  - out_valid = 0, in_ready = 1
  - stored entries = 0, so out_word = 0 and out_nan, out_inf, out_zero = 0
  - flag_invalid, flag_overflow = 0; nan_count, ovf_count = 0
- Reset mid-operation discards all buffered entries. The first push after rst_n rises behaves as on an empty FIFO.

## Test plan
- Normal stream: push {0, 8'h80, 24'hC00000} with out_ready = 1 → out_word = 32'h40400000 one cycle later, class bits 0, in_ready stays 1.
- Exceptions:
  - push in_error = 1 → word 32'h7FC00000, out_nan = 1, flag_invalid = 1, nan_count = 1.
  - push in_overflow = 1, sign 1 → word 32'hFF800000, out_inf = 1, ovf_count = 1.
  - push in_exp = 0, sign 1 → word 32'h80000000, out_zero = 1.
- Backpressure: out_ready = 0, push A then B → in_ready = 0 after the second push. A third in_valid is held and not accepted. Raise out_ready → A pops, then B, then C; order A, B, C preserved.
- Simultaneous push/pop at count = 1 for 10 cycles → count stays 1, every word emerges exactly one cycle after its push. At count = 2 with out_ready = 1, the input is not accepted in that cycle.
- Counters: with CNT_W = 8, push 300 error results → nan_count = 255. Then clr_flags together with one error push → nan_count = 1, flag_invalid = 1.
- Reset: with 2 entries buffered and flags set, pulse rst_n low mid-cycle → out_valid = 0 and in_ready = 1 immediately, all flags and counters = 0, and the next push appears with 1-cycle latency.
